mem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single-port 512 x 32 synchronous RAM between instruction fetch (port A, read-only) and data load/store (port B, read/write).
- Registers the RAM control signals and accepts at most one access per cycle.
- Tracks the one-cycle RAM read latency and routes returned read data to the requester that issued the read.
- Sits between the CPU fetch/memory stages and the RAM.

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared single-port 512x32 RAM (A: fetch reads, B: load/store).
// Fixed priority B > A by default; define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dataIn,
  input  logic [DATA_W-1:0] dataOut
);

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_A,
    TAG_B
  } ret_tag_t;

  ret_tag_t          retTag;
  ret_tag_t          retTagNext;
  logic              aElig;
  logic              bElig;
  logic              aWin;
  logic              bWin;
  logic              memReadNext;
  logic              memWriteNext;
  logic              aGntNext;
  logic              bGntNext;
  logic [ADDR_W-1:0] addressNext;
  logic [DATA_W-1:0] dataInNext;

  // Masking by the current grant keeps a held request from being accepted twice.
  assign aElig = a_req && !a_gnt;
  assign bElig = b_req && !b_gnt;

`ifdef MEM_ARB_RR_EN
  logic rrPtr;
  logic rrPtrNext;

  // rrPtr = 0 prefers A; it only flips when both ports contend.
  always_comb begin
    aWin      = aElig && (!bElig || !rrPtr);
    bWin      = bElig && (!aElig || rrPtr);
    rrPtrNext = rrPtr;
    if (aElig && bElig) begin
      rrPtrNext = !rrPtr;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rrPtr <= 1'b0;
    end else begin
      rrPtr <= rrPtrNext;
    end
  end
`else
  always_comb begin
    bWin = bElig;
    aWin = aElig && !bElig;
  end
`endif

  // The tag follows memRead by one cycle, lining up with the RAM's read data.
  always_comb begin
    memReadNext  = 1'b0;
    memWriteNext = 1'b0;
    aGntNext     = aWin;
    bGntNext     = bWin;
    addressNext  = address;
    dataInNext   = dataIn;
    retTagNext   = TAG_NONE;
    if (memRead) begin
      retTagNext = a_gnt ? TAG_A : TAG_B;
    end
    if (bWin) begin
      addressNext  = b_addr;
      memReadNext  = !b_we;
      memWriteNext = b_we;
      if (b_we) begin
        dataInNext = b_wdata;
      end
    end else if (aWin) begin
      addressNext = a_addr;
      memReadNext = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      memRead  <= 1'b0;
      memWrite <= 1'b0;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      address  <= '0;
      dataIn   <= '0;
      retTag   <= TAG_NONE;
    end else begin
      memRead  <= memReadNext;
      memWrite <= memWriteNext;
      a_gnt    <= aGntNext;
      b_gnt    <= bGntNext;
      address  <= addressNext;
      dataIn   <= dataInNext;
      retTag   <= retTagNext;
    end
  end

  assign a_rvalid = (retTag == TAG_A);
  assign b_rvalid = (retTag == TAG_B);
  assign a_rdata  = dataOut;
  assign b_rdata  = dataOut;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural 512x32 RAM, per-port read-data scoreboard.
// Expected grant order adapts to MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n;
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut;

  logic [DATA_W-1:0] ram    [0:511];
  logic [DATA_W-1:0] refMem [0:511];
  bit                ramLoaded = 1'b0;
  logic [DATA_W-1:0] aQ[$];
  logic [DATA_W-1:0] bQ[$];
  logic [DATA_W-1:0] aExp;
  logic [DATA_W-1:0] bExp;
  int                checks = 0;
  int                errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .memRead(memRead), .memWrite(memWrite), .address(address), .dataIn(dataIn),
    .dataOut(dataOut)
  );

  always #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] initWord(input int i);
    if (i == 5) return 32'hDEADBEEF;
    if (i == 32'h40) return 32'h0;
    return 32'hA5000000 ^ (i * 32'h00010101);
  endfunction

  // Synchronous RAM: preloaded on the first edge (during reset), read data one cycle after memRead.
  always @(posedge clock) begin
    if (!ramLoaded) begin
      for (int i = 0; i < 512; i++) ram[i] <= initWord(i);
      ramLoaded <= 1'b1;
    end else begin
      if (memWrite) ram[address] <= dataIn;
      if (memRead) dataOut <= ram[address];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Scoreboard side: every returned read is matched against the oldest expected word for its port.
  always @(negedge clock) begin
    if (a_rvalid) begin
      if (aQ.size() == 0) checkOutput("a_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        aExp = aQ.pop_front();
        checkOutput("a_rdata", a_rdata, aExp);
      end
    end
    if (b_rvalid) begin
      if (bQ.size() == 0) checkOutput("b_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        bExp = bQ.pop_front();
        checkOutput("b_rdata", b_rdata, bExp);
      end
    end
    if (a_gnt || b_gnt) checkOutput("gnt_onehot", 32'(a_gnt & b_gnt), 32'd0);
  end

  task automatic doReset();
    @(negedge clock);
    a_req   = 1'b0;
    b_req   = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Single uncontested access: gnt expected exactly one cycle after the request, rvalid one after that.
  task automatic applyStimulus(input bit isB, input bit we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata);
    int    cnt;
    bit    seen;
    string p;
    p = isB ? "b" : "a";
    @(posedge clock);
    #1;
    if (isB) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = 1'b1; a_addr = addr;
    end
    if (we) refMem[addr] = wdata;
    else if (isB) bQ.push_back(refMem[addr]);
    else aQ.push_back(refMem[addr]);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 10) begin
      @(negedge clock);
      cnt++;
      seen = isB ? b_gnt : a_gnt;
    end
    checkOutput({p, "_gnt_cycle"}, 32'(cnt), 32'd2);
    if (seen) begin
      checkOutput({p, "_address"}, 32'(address), 32'(addr));
      checkOutput({p, "_memRead"}, 32'(memRead), 32'(!we));
      checkOutput({p, "_memWrite"}, 32'(memWrite), 32'(we));
      if (we) checkOutput({p, "_dataIn"}, dataIn, wdata);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clock);
    checkOutput({p, "_rvalid_timing"}, 32'(isB ? b_rvalid : a_rvalid), 32'(!we));
  endtask

  // Both ports request in the same cycle; grant order, addresses and rvalid cycles are checked.
  task automatic contend(input string name, input logic [ADDR_W-1:0] aAddr, input bit bWe,
                         input logic [ADDR_W-1:0] bAddr, input logic [DATA_W-1:0] bWdata,
                         input bit expBFirst);
    bit                order[$];
    logic [ADDR_W-1:0] addrs[$];
    int                aRv;
    int                bRv;
    aRv = -1;
    bRv = -1;
    @(posedge clock);
    #1;
    a_req = 1'b1; a_addr = aAddr;
    b_req = 1'b1; b_we = bWe; b_addr = bAddr; b_wdata = bWdata;
    if (expBFirst) begin
      if (bWe) refMem[bAddr] = bWdata; else bQ.push_back(refMem[bAddr]);
      aQ.push_back(refMem[aAddr]);
    end else begin
      aQ.push_back(refMem[aAddr]);
      if (bWe) refMem[bAddr] = bWdata; else bQ.push_back(refMem[bAddr]);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (b_gnt) begin order.push_back(1'b1); addrs.push_back(address); b_req = 1'b0; end
      if (a_gnt) begin order.push_back(1'b0); addrs.push_back(address); a_req = 1'b0; end
      if (a_rvalid) aRv = c;
      if (b_rvalid) bRv = c;
    end
    a_req = 1'b0;
    b_req = 1'b0;
    checkOutput({name, "_grant_count"}, 32'(order.size()), 32'd2);
    if (order.size() == 2) begin
      checkOutput({name, "_first"}, 32'(order[0]), 32'(expBFirst));
      checkOutput({name, "_first_addr"}, 32'(addrs[0]), 32'(expBFirst ? bAddr : aAddr));
      checkOutput({name, "_second_addr"}, 32'(addrs[1]), 32'(expBFirst ? aAddr : bAddr));
    end
    checkOutput({name, "_a_rvalid_cycle"}, 32'(aRv), 32'(expBFirst ? 3 : 2));
    checkOutput({name, "_b_rvalid_cycle"}, 32'(bRv), bWe ? 32'hFFFFFFFF : 32'(expBFirst ? 2 : 3));
  endtask

  // Both requests held for 8 cycles straight after reset.
  task automatic holdBoth();
    int aCnt;
    int bCnt;
    bit expA;
    aCnt = 0;
    bCnt = 0;
    doReset();
    @(posedge clock);
    #1;
    a_req = 1'b1; a_addr = 9'h005;
    b_req = 1'b1; b_we = 1'b0; b_addr = 9'h1FF;
    @(negedge clock);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      expA = RR_MODE ? (c % 2 == 1) : (c % 2 == 0);
      checkOutput("hold_a_gnt", 32'(a_gnt), 32'(expA));
      checkOutput("hold_b_gnt", 32'(b_gnt), 32'(!expA));
      if (a_gnt) begin aCnt++; aQ.push_back(refMem[9'h005]); end
      if (b_gnt) begin bCnt++; bQ.push_back(refMem[9'h1FF]); end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    checkOutput("hold_a_count", 32'(aCnt), 32'd4);
    checkOutput("hold_b_count", 32'(bCnt), 32'd4);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 512; i++) refMem[i] = initWord(i);
    reset_n = 1'b0;
    a_req   = 1'b0;
    a_addr  = '0;
    b_req   = 1'b0;
    b_we    = 1'b0;
    b_addr  = '0;
    b_wdata = '0;
    repeat (2) @(negedge clock);
    checkOutput("rst_memRead", 32'(memRead), 32'd0);
    checkOutput("rst_memWrite", 32'(memWrite), 32'd0);
    checkOutput("rst_gnts", 32'({a_gnt, b_gnt}), 32'd0);
    checkOutput("rst_rvalids", 32'({a_rvalid, b_rvalid}), 32'd0);
    checkOutput("rst_address", 32'(address), 32'd0);
    checkOutput("rst_dataIn", dataIn, 32'd0);
    reset_n = 1'b1;

    // Reset asserted while a read is on the RAM port: the read must vanish.
    @(posedge clock);
    #1;
    a_req = 1'b1; a_addr = 9'h010;
    @(negedge clock);
    @(negedge clock);
    checkOutput("mid_memRead_before", 32'(memRead), 32'd1);
    a_req = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checkOutput("mid_memRead_async", 32'(memRead), 32'd0);
    checkOutput("mid_gnt_async", 32'(a_gnt), 32'd0);
    checkOutput("mid_address_async", 32'(address), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checkOutput("mid_no_rvalid", 32'(a_rvalid), 32'd0);
    end

    applyStimulus(1'b0, 1'b0, 9'h005, 32'h0);
    applyStimulus(1'b1, 1'b1, 9'h1FF, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 9'h1FF, 32'h0);
    contend("contend", 9'h001, 1'b0, 9'h002, 32'h0, !RR_MODE);
    contend("hazard", 9'h040, 1'b1, 9'h040, 32'hCAFEF00D, 1'b1);
    holdBoth();

    repeat (4) @(negedge clock);
    checkOutput("a_queue_drained", 32'(aQ.size()), 32'd0);
    checkOutput("b_queue_drained", 32'(bQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
